// File: rtl/mips_pkg.sv
// Shared MIPS definitions: HI/LO unit op encodings, FSM states and datapath width.
package mips_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    MD_MULT = 2'b00,
    MD_DIV  = 2'b01,
    MD_MTHI = 2'b10,
    MD_MTLO = 2'b11
  } mdOp_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } mdState_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit owning the HI/LO registers.
// Define MULDIV_SIGNED_EN to honour is_signed; otherwise every MULT/DIV is unsigned.
module muldiv_unit
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  mdState_t            state, nextState;
  mdOp_t               opCode;
  logic                signedMode;
  logic                accept;
  logic [DATA_W-1:0]   aMag, bMag;

  // Shared datapath: acc holds {partial product, multiplier} or {remainder, quotient}.
  logic [2*DATA_W-1:0] acc, accStep;
  logic [DATA_W-1:0]   operand;
  logic [4:0]          iterCnt;
  logic                isDivOp, negRes, negRem, divByZero;
  logic [DATA_W:0]     addSum, trial;
  logic [2*DATA_W-1:0] prodFix;
  logic [DATA_W-1:0]   quoFix, remFix;

  assign opCode = mdOp_t'(op);

`ifdef MULDIV_SIGNED_EN
  assign signedMode = is_signed;
`else
  // Tied off so every sign-correction path below folds away as constant.
  assign signedMode = is_signed & 1'b0;
`endif

  assign aMag   = (signedMode && a[DATA_W-1]) ? -a : a;
  assign bMag   = (signedMode && b[DATA_W-1]) ? -b : b;
  assign accept = (state == IDLE) && start && (opCode == MD_MULT || opCode == MD_DIV);
  assign busy   = (state != IDLE);

  // Shift-add uses the 33-bit sum as the new upper half; restoring divide compares
  // the 33-bit shifted remainder against the divisor and keeps it only without borrow.
  assign addSum = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, (acc[0] ? operand : '0)};
  assign trial  = acc[2*DATA_W-1:DATA_W-1] - {1'b0, operand};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    accStep = acc;
    if (isDivOp) begin
      if (!trial[DATA_W]) accStep = {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      else                accStep = {acc[2*DATA_W-2:0], 1'b0};
    end else begin
      accStep = {addSum, acc[DATA_W-1:1]};
    end
  end

  assign prodFix = negRes ? -acc : acc;
  assign quoFix  = negRes ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign remFix  = negRem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = (opCode == MD_DIV && b == '0) ? FIN : CALC;
      CALC: if (iterCnt == 5'd31) nextState = FIN;
      FIN:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      acc       <= '0;
      operand   <= '0;
      iterCnt   <= '0;
      isDivOp   <= 1'b0;
      negRes    <= 1'b0;
      negRem    <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      state    <= nextState;
      done     <= (state == FIN);
      div_zero <= (state == FIN) && divByZero;
      case (state)
        IDLE: begin
          if (start) begin
            case (opCode)
              MD_MTHI: hi <= a;
              MD_MTLO: lo <= a;
              default: begin
                isDivOp   <= (opCode == MD_DIV);
                acc       <= {{DATA_W{1'b0}}, aMag};
                operand   <= bMag;
                iterCnt   <= '0;
                negRes    <= signedMode && (a[DATA_W-1] ^ b[DATA_W-1]);
                negRem    <= signedMode && a[DATA_W-1];
                divByZero <= (opCode == MD_DIV) && (b == '0);
              end
            endcase
          end
        end
        CALC: begin
          acc     <= accStep;
          iterCnt <= iterCnt + 5'd1;
        end
        FIN: begin
          if (!divByZero) begin
            if (isDivOp) begin
              hi <= remFix;
              lo <= quoFix;
            end else begin
              {hi, lo} <= prodFix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized ops
// checked against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, is_signed;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checkCnt = 0;
  int passCnt  = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    if (obs === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Returns {hi, lo} as the architecture defines them, from plain 64-bit arithmetic.
  function automatic logic [63:0] refResult(input logic [1:0] o, input logic s,
                                            input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy, uq, ur;
    bit useSigned;
    useSigned = s;
`ifndef MULDIV_SIGNED_EN
    useSigned = 1'b0;
`endif
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'h0, x};
    uy = {32'h0, y};
    if (o == MD_MULT) begin
      if (useSigned) return 64'(sx * sy);
      return ux * uy;
    end
    if (useSigned) begin
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
    end
    uq = ux / uy;
    ur = ux % uy;
    return {ur[31:0], uq[31:0]};
  endfunction

  task automatic runOp(input logic [1:0] o, input logic s, input logic [31:0] x,
                       input logic [31:0] y, input bit inject);
    int lat, busyCyc, expLat;
    bit dz;
    @(negedge clk);
    op = o; is_signed = s; a = x; b = y; start = 1'b1;
    dz = (o == MD_DIV) && (y == 32'h0);
    if (!dz) {mHi, mLo} = refResult(o, s, x, y);
    expLat = dz ? 1 : 33;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom; is_signed = 1'($urandom);
    lat = 0;
    busyCyc = 0;
    while (!done && lat < 200) begin
      busyCyc += int'(busy);
      lat++;
      if (inject) begin
        start = 1'($urandom); op = 2'($urandom); a = $urandom; b = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("latency",      64'(lat),     64'(expLat));
    check("busy_cycles",  64'(busyCyc), 64'(expLat));
    check("busy_at_done", 64'(busy),    64'(0));
    check("div_zero",     64'(div_zero), 64'(dz));
    check("hi",           64'(hi),      64'(mHi));
    check("lo",           64'(lo),      64'(mLo));
    @(negedge clk);
    check("done_pulse",     64'(done),     64'(0));
    check("div_zero_pulse", 64'(div_zero), 64'(0));
  endtask

  task automatic runMt(input logic [1:0] o, input logic [31:0] x);
    @(negedge clk);
    op = o; a = x; start = 1'b1;
    if (o == MD_MTHI) mHi = x;
    else              mLo = x;
    @(negedge clk);
    start = 1'b0;
    check("mt_busy", 64'(busy), 64'(0));
    check("mt_done", 64'(done), 64'(0));
    check("mt_hi",   64'(hi),   64'(mHi));
    check("mt_lo",   64'(lo),   64'(mLo));
  endtask

  initial begin
    int seen;
    logic [1:0] o;
    logic [31:0] y;
    // Reset held together with a MULT request: reset must win.
    rst = 1'b1; start = 1'b1; op = MD_MULT; is_signed = 1'b0; a = 32'd3; b = 32'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_busy",     64'(busy),     64'(0));
    check("rst_done",     64'(done),     64'(0));
    check("rst_div_zero", 64'(div_zero), 64'(0));
    check("rst_hi",       64'(hi),       64'(0));
    check("rst_lo",       64'(lo),       64'(0));

    runOp(MD_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    runOp(MD_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    runOp(MD_DIV,  1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    runOp(MD_DIV,  1'b0, 32'd100, 32'd7, 1'b0);
    runOp(MD_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    runMt(MD_MTHI, 32'h1234);
    runMt(MD_MTLO, 32'h5678);
    runOp(MD_DIV,  1'b0, 32'd9, 32'd0, 1'b0);
    runOp(MD_MULT, 1'b0, $urandom, $urandom, 1'b1);

    // Abort a MULT with reset partway through: no result, registers cleared.
    @(negedge clk);
    op = MD_MULT; is_signed = 1'b0; a = 32'd11; b = 32'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mHi = '0;
    mLo = '0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_hi",   64'(hi),   64'(0));
    check("abort_lo",   64'(lo),   64'(0));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen += int'(done);
    end
    check("abort_no_done", 64'(seen), 64'(0));
    runOp(MD_MULT, 1'b0, 32'd6, 32'd7, 1'b0);

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      if (o == MD_MTHI || o == MD_MTLO) begin
        runMt(o, $urandom);
      end else begin
        y = $urandom;
        if (o == MD_DIV && $urandom_range(0, 7) == 0) y = 32'h0;
        else if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 20));
        runOp(o, 1'($urandom), $urandom, y, bit'($urandom));
      end
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
